// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller and the unified memory port.
//   mem_req   : access request (controller -> memory)
//   mem_we    : write qualifier for mem_req
//   adr_src   : address select, 0 = PC, 1 = ALU-result register
//   mem_ready : memory completes the request this cycle (memory -> controller)
interface multicycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle Moore sequencer for the micro ARM core. Steps the shared datapath one phase per
// cycle, holds the NZCV flags, annuls instructions whose condition fails and stalls on the
// memory ready/valid handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cond/op/funct/rd    : instruction register fields
//   alu_flags           : {N,Z,C,V} from the ALU this cycle
//   mem                 : memory handshake (mem_req, mem_we, adr_src out; mem_ready in)
//   ir_we/pc_we/reg_we  : datapath write enables
//   alu_src_a/b, alu_ctrl, result_src, imm_src, reg_src : datapath mux selects
//   flags               : architectural NZCV register
//   state               : current FSM state (debug)
//   instr_done          : one-cycle pulse when an instruction retires or is annulled
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [3:0]                     cond,
  input  logic [1:0]                     op,
  input  logic [5:0]                     funct,
  input  logic [3:0]                     rd,
  input  logic [3:0]                     alu_flags,
  multicycle_controller_if.master        mem,
  output logic                           ir_we,
  output logic                           pc_we,
  output logic                           reg_we,
  output logic                           alu_src_a,
  output logic [1:0]                     alu_src_b,
  output logic [1:0]                     alu_ctrl,
  output logic [1:0]                     result_src,
  output logic [1:0]                     imm_src,
  output logic [1:0]                     reg_src,
  output logic [3:0]                     flags,
  output logic [3:0]                     state,
  output logic                           instr_done
);

  localparam logic [1:0] OpDp  = 2'b00;
  localparam logic [1:0] OpMem = 2'b01;
  localparam logic [1:0] OpB   = 2'b10;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluSub = 2'b01;
  localparam logic [1:0] AluAnd = 2'b10;
  localparam logic [1:0] AluOrr = 2'b11;

  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdOrr = 4'b1100;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExr    = 4'd6,
    StExi    = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  // DP operation decode
  logic [1:0] dp_alu_ctrl;
  logic       dp_known;
  logic       dp_arith;

  always_comb begin
    dp_alu_ctrl = AluAdd;
    dp_known    = 1'b0;
    dp_arith    = 1'b0;
    case (funct[4:1])
      CmdAdd: begin dp_alu_ctrl = AluAdd; dp_known = 1'b1; dp_arith = 1'b1; end
      CmdSub: begin dp_alu_ctrl = AluSub; dp_known = 1'b1; dp_arith = 1'b1; end
      CmdAnd: begin dp_alu_ctrl = AluAnd; dp_known = 1'b1; end
      CmdOrr: begin dp_alu_ctrl = AluOrr; dp_known = 1'b1; end
      default: ;
    endcase
  end

  // ARM condition table against the architectural flags
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  // Flags update at the end of an execute phase; logic ops keep C and V
  always_comb begin
    flags_d = flags_q;
    if ((state_q == StExr || state_q == StExi) && funct[0] && dp_known) begin
      flags_d[3:2] = alu_flags[3:2];
      if (dp_arith) flags_d[1:0] = alu_flags[1:0];
    end
  end

  // Raw enables before reset gating
  logic mem_req_raw, mem_we_raw, ir_we_raw, pc_we_raw, reg_we_raw, done_raw;

  always_comb begin
    state_d     = state_q;
    mem_req_raw = 1'b0;
    mem_we_raw  = 1'b0;
    mem.adr_src = 1'b0;
    ir_we_raw   = 1'b0;
    pc_we_raw   = 1'b0;
    reg_we_raw  = 1'b0;
    done_raw    = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_ctrl    = AluAdd;
    result_src  = 2'd0;

    case (state_q)
      StFetch: begin
        mem_req_raw = 1'b1;
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        result_src  = 2'd2;
        ir_we_raw   = mem.mem_ready;
        pc_we_raw   = mem.mem_ready;
        if (mem.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (!cond_pass) begin
          state_d  = StFetch;
          done_raw = 1'b1;
        end else begin
          case (op)
            OpMem:   state_d = StMemAdr;
            OpB:     state_d = StBranch;
            OpDp:    state_d = funct[5] ? StExi : StExr;
            default: begin
              state_d  = StFetch;
              done_raw = 1'b1;
            end
          endcase
        end
      end
      StMemAdr: begin
        alu_src_b = 2'd1;
        state_d   = funct[0] ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req_raw = 1'b1;
        mem.adr_src = 1'b1;
        if (mem.mem_ready) state_d = StMemWb;
      end
      StMemWr: begin
        mem_req_raw = 1'b1;
        mem_we_raw  = 1'b1;
        mem.adr_src = 1'b1;
        if (mem.mem_ready) begin
          state_d  = StFetch;
          done_raw = 1'b1;
        end
      end
      StMemWb: begin
        result_src = 2'd1;
        reg_we_raw = (rd != 4'd15);
        pc_we_raw  = (rd == 4'd15);
        state_d    = StFetch;
        done_raw   = 1'b1;
      end
      StExr: begin
        alu_ctrl = dp_alu_ctrl;
        state_d  = StAluWb;
      end
      StExi: begin
        alu_src_b = 2'd1;
        alu_ctrl  = dp_alu_ctrl;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_we_raw = (rd != 4'd15);
        pc_we_raw  = (rd == 4'd15);
        state_d    = StFetch;
        done_raw   = 1'b1;
      end
      StBranch: begin
        alu_src_b  = 2'd1;
        result_src = 2'd2;
        pc_we_raw  = 1'b1;
        state_d    = StFetch;
        done_raw   = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset forces every write/request low combinationally so an abort cannot glitch an enable
  assign mem.mem_req = mem_req_raw & rst_n;
  assign mem.mem_we  = mem_we_raw & rst_n;
  assign ir_we       = ir_we_raw & rst_n;
  assign pc_we       = pc_we_raw & rst_n;
  assign reg_we      = reg_we_raw & rst_n;
  assign instr_done  = done_raw & rst_n;

  assign imm_src = op;
  assign reg_src = {(op == OpMem) && !funct[0], op == OpB};
  assign flags   = flags_q;
  assign state   = state_q;

endmodule
